// File: rtl/carfield_region_decoder.sv
// Runtime-programmable address region decoder.
// Two-stage lookup pipeline with overlap flagging and miss capture.
module carfield_region_decoder #(
   parameter int unsigned          NumRegions  = 8,
   parameter int unsigned          AddrWidth   = 64,
   parameter int unsigned          IdxWidth    = $clog2(NumRegions),
   parameter logic [NumRegions-1:0] ResetEnable = '0,
   parameter int unsigned          CntWidth    = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [IdxWidth-1:0]  cfg_idx_i,
   input  logic [1:0]           cfg_field_i,
   input  logic [AddrWidth-1:0] cfg_wdata_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic                 rsp_hit_o,
   output logic [IdxWidth-1:0]  rsp_idx_o,
   output logic                 rsp_multi_o,
   output logic                 err_valid_o,
   output logic [AddrWidth-1:0] err_addr_o,
   output logic [CntWidth-1:0]  err_cnt_o,
   input  logic                 err_clear_i,
   output logic                 busy_o
);

   typedef logic [AddrWidth-1:0] addr_t;

   // region table
   addr_t                 base_q [NumRegions];
   addr_t                 base_d [NumRegions];
   addr_t                 size_q [NumRegions];
   addr_t                 size_d [NumRegions];
   logic [NumRegions-1:0] en_q;
   logic [NumRegions-1:0] en_d;

   // stage 1
   logic                  s1_valid_q, s1_valid_d;
   addr_t                 s1_addr_q, s1_addr_d;

   // stage 2
   logic                  s2_valid_q, s2_valid_d;
   logic                  s2_hit_q, s2_hit_d;
   logic [IdxWidth-1:0]   s2_idx_q, s2_idx_d;
   logic                  s2_multi_q, s2_multi_d;
   addr_t                 s2_addr_q, s2_addr_d;

   // error capture
   logic                  err_valid_q, err_valid_d;
   addr_t                 err_addr_q, err_addr_d;
   logic [CntWidth-1:0]   err_cnt_q, err_cnt_d;

   // handshakes and match reduction
   logic                  cfg_fire;
   logic                  req_fire;
   logic                  rsp_fire;
   logic                  miss_fire;
   logic                  s2_adv;
   logic [NumRegions-1:0] match;
   logic                  hit;
   logic                  multi;
   logic [IdxWidth-1:0]   idx;

   // handshake and flow-control signals
   always_comb begin
      busy_o      = s1_valid_q | s2_valid_q;
      s2_adv      = ~s2_valid_q | rsp_ready_i;
      cfg_ready_o = ~busy_o;
      req_ready_o = ~cfg_valid_i & (~s1_valid_q | s2_adv);
      cfg_fire    = cfg_valid_i & cfg_ready_o;
      req_fire    = req_valid_i & req_ready_o;
      rsp_fire    = s2_valid_q & rsp_ready_i;
      miss_fire   = rsp_fire & ~s2_hit_q;
   end

   // region table writes; out-of-range index and reserved field fall through
   always_comb begin
      base_d = base_q;
      size_d = size_q;
      en_d   = en_q;
      if (cfg_fire) begin
         for (int i = 0; i < NumRegions; i++) begin
            if (cfg_idx_i == IdxWidth'(i)) begin
               case (cfg_field_i)
                  2'd0:    base_d[i] = cfg_wdata_i;
                  2'd1:    size_d[i] = cfg_wdata_i;
                  2'd2:    en_d[i]   = cfg_wdata_i[0];
                  default: ;
               endcase
            end
         end
      end
   end

   // per-region match on the stage-1 address; offset taken after the >= check
   always_comb begin
      match = '0;
      for (int i = 0; i < NumRegions; i++) begin
         match[i] = en_q[i]
                  & (size_q[i] != '0)
                  & (s1_addr_q >= base_q[i])
                  & ((s1_addr_q - base_q[i]) < size_q[i]);
      end
   end

   // reduce match vector to hit, lowest index and multi flag
   always_comb begin
      hit   = |match;
      multi = |(match & (match - NumRegions'(1)));
      idx   = '0;
      for (int i = NumRegions - 1; i >= 0; i--) begin
         if (match[i]) begin
            idx = IdxWidth'(i);
         end
      end
   end

   // stage 1 holds while stage 2 is stalled
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_addr_d  = s1_addr_q;
      if (req_fire) begin
         s1_valid_d = 1'b1;
         s1_addr_d  = req_addr_i;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // stage 2 keeps its result stable until consumed
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_hit_d   = s2_hit_q;
      s2_idx_d   = s2_idx_q;
      s2_multi_d = s2_multi_q;
      s2_addr_d  = s2_addr_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_hit_d   = hit;
            s2_idx_d   = idx;
            s2_multi_d = multi;
            s2_addr_d  = s1_addr_q;
         end
      end
   end

   // miss capture: clear first, then count and latch the first address
   always_comb begin
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      err_cnt_d   = err_cnt_q;
      if (err_clear_i) begin
         err_valid_d = 1'b0;
         err_addr_d  = '0;
         err_cnt_d   = '0;
      end
      if (miss_fire) begin
         if (err_cnt_d != '1) begin
            err_cnt_d = err_cnt_d + CntWidth'(1);
         end
         if (!err_valid_d) begin
            err_valid_d = 1'b1;
            err_addr_d  = s2_addr_q;
         end
      end
   end

   // state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumRegions; i++) begin
            base_q[i] <= '0;
            size_q[i] <= '0;
         end
         en_q        <= ResetEnable;
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_hit_q    <= 1'b0;
         s2_idx_q    <= '0;
         s2_multi_q  <= 1'b0;
         s2_addr_q   <= '0;
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         for (int i = 0; i < NumRegions; i++) begin
            base_q[i] <= base_d[i];
            size_q[i] <= size_d[i];
         end
         en_q        <= en_d;
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         s2_valid_q  <= s2_valid_d;
         s2_hit_q    <= s2_hit_d;
         s2_idx_q    <= s2_idx_d;
         s2_multi_q  <= s2_multi_d;
         s2_addr_q   <= s2_addr_d;
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // response and error outputs
   always_comb begin
      rsp_valid_o = s2_valid_q;
      rsp_hit_o   = s2_hit_q;
      rsp_idx_o   = s2_idx_q;
      rsp_multi_o = s2_multi_q;
      err_valid_o = err_valid_q;
      err_addr_o  = err_addr_q;
      err_cnt_o   = err_cnt_q;
   end

endmodule

// File: tb/tb_carfield_region_decoder.sv
// Testbench for carfield_region_decoder.
// Directed steps with a response scoreboard and error-register model.
module tb_carfield_region_decoder;

   localparam int N  = 8;
   localparam int AW = 64;
   localparam int IW = 3;
   localparam int CW = 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          cfg_valid_i;
   logic          cfg_ready_o;
   logic [IW-1:0] cfg_idx_i;
   logic [1:0]    cfg_field_i;
   logic [AW-1:0] cfg_wdata_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic          rsp_hit_o;
   logic [IW-1:0] rsp_idx_o;
   logic          rsp_multi_o;
   logic          err_valid_o;
   logic [AW-1:0] err_addr_o;
   logic [CW-1:0] err_cnt_o;
   logic          err_clear_i;
   logic          busy_o;

   carfield_region_decoder dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_idx_i   (cfg_idx_i),
      .cfg_field_i (cfg_field_i),
      .cfg_wdata_i (cfg_wdata_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_hit_o   (rsp_hit_o),
      .rsp_idx_o   (rsp_idx_o),
      .rsp_multi_o (rsp_multi_o),
      .err_valid_o (err_valid_o),
      .err_addr_o  (err_addr_o),
      .err_cnt_o   (err_cnt_o),
      .err_clear_i (err_clear_i),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic          hit;
      logic [IW-1:0] idx;
      logic          multi;
      logic [AW-1:0] addr;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   exp_t          q[$];
   logic [AW-1:0] m_base [N];
   logic [AW-1:0] m_size [N];
   logic          m_en   [N];
   logic          m_err_v;
   logic [AW-1:0] m_err_a;
   int            m_err_c;
   logic          p_stall;
   logic          p_hit;
   logic [IW-1:0] p_idx;
   logic          p_multi;

   task automatic chk(input string tag, input logic [AW-1:0] obs,
                      input logic [AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < N; i++) begin
         m_base[i] = '0;
         m_size[i] = '0;
         m_en[i]   = 1'b0;
      end
      m_err_v = 1'b0;
      m_err_a = '0;
      m_err_c = 0;
      p_stall = 1'b0;
      q.delete();
   endtask

   function automatic exp_t predict(input logic [AW-1:0] a);
      exp_t e;
      int   n;
      e      = '0;
      e.addr = a;
      n      = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (m_en[i] && m_size[i] != 0 && a >= m_base[i]
             && (a - m_base[i]) < m_size[i]) begin
            n++;
            e.idx = IW'(i);
         end
      end
      e.hit   = (n > 0);
      e.multi = (n > 1);
      return e;
   endfunction

   // monitor: sampled on the falling edge, handshakes complete on the next rise
   always @(negedge clk_i) begin
      if (!rst_i) begin
         chk("err_valid", err_valid_o, m_err_v);
         chk("err_addr", err_addr_o, m_err_a);
         chk("err_cnt", err_cnt_o, m_err_c);
         if (p_stall && rsp_valid_o) begin
            chk("stall_hit", rsp_hit_o, p_hit);
            chk("stall_idx", rsp_idx_o, p_idx);
            chk("stall_multi", rsp_multi_o, p_multi);
         end
         p_stall = rsp_valid_o && !rsp_ready_i;
         p_hit   = rsp_hit_o;
         p_idx   = rsp_idx_o;
         p_multi = rsp_multi_o;
         if (cfg_valid_i && cfg_ready_o && int'(cfg_idx_i) < N) begin
            case (cfg_field_i)
               2'd0:    m_base[cfg_idx_i] = cfg_wdata_i;
               2'd1:    m_size[cfg_idx_i] = cfg_wdata_i;
               2'd2:    m_en[cfg_idx_i]   = cfg_wdata_i[0];
               default: ;
            endcase
         end
         if (req_valid_i && req_ready_o) begin
            q.push_back(predict(req_addr_i));
         end
         if (err_clear_i) begin
            m_err_v = 1'b0;
            m_err_a = '0;
            m_err_c = 0;
         end
         if (rsp_valid_o && rsp_ready_i) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL rsp_extra observed=1 expected=0");
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_hit", rsp_hit_o, e.hit);
               chk("rsp_idx", rsp_idx_o, e.idx);
               chk("rsp_multi", rsp_multi_o, e.multi);
               if (!e.hit) begin
                  if (m_err_c < 255) m_err_c++;
                  if (!m_err_v) begin
                     m_err_v = 1'b1;
                     m_err_a = e.addr;
                  end
               end
            end
         end
      end
   end

   task automatic cfg_write(input int idx, input int fld,
                            input logic [AW-1:0] d);
      int n;
      n           = 0;
      cfg_valid_i = 1'b1;
      cfg_idx_i   = IW'(idx);
      cfg_field_i = 2'(fld);
      cfg_wdata_i = d;
      do begin
         @(negedge clk_i);
         n++;
      end while (!cfg_ready_o && n < 100);
      @(posedge clk_i);
      #1;
      cfg_valid_i = 1'b0;
      chk("cfg_timeout", (n < 100), 1);
   endtask

   task automatic region(input int idx, input logic [AW-1:0] b,
                         input logic [AW-1:0] s);
      cfg_write(idx, 0, b);
      cfg_write(idx, 1, s);
      cfg_write(idx, 2, 1);
   endtask

   task automatic lookup(input logic [AW-1:0] a);
      int n;
      n           = 0;
      req_valid_i = 1'b1;
      req_addr_i  = a;
      do begin
         @(negedge clk_i);
         n++;
      end while (!req_ready_o && n < 100);
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      chk("req_timeout", (n < 100), 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (n < 100) begin
         @(negedge clk_i);
         if (q.size() == 0 && !busy_o) break;
         n++;
      end
      @(posedge clk_i);
      #1;
      chk("drain_timeout", (n < 100), 1);
   endtask

   int n;

   initial begin
      reset_model();
      rst_i       = 1'b1;
      cfg_valid_i = 1'b0;
      cfg_idx_i   = '0;
      cfg_field_i = '0;
      cfg_wdata_i = '0;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      rsp_ready_i = 1'b1;
      err_clear_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk("rst_cfg_ready", cfg_ready_o, 1);
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_hit", rsp_hit_o, 0);
      chk("rst_rsp_idx", rsp_idx_o, 0);
      chk("rst_rsp_multi", rsp_multi_o, 0);
      chk("rst_err_valid", err_valid_o, 0);
      chk("rst_err_addr", err_addr_o, 0);
      chk("rst_err_cnt", err_cnt_o, 0);
      chk("rst_busy", busy_o, 0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // basic hit with 2-cycle latency, then a miss
      region(0, 64'h7800_0000, 64'h20_0000);
      req_valid_i = 1'b1;
      req_addr_i  = 64'h781F_FFFF;
      @(negedge clk_i);
      chk("lat_req_ready", req_ready_o, 1);
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      chk("lat_s1_valid", rsp_valid_o, 0);
      chk("lat_s1_busy", busy_o, 1);
      @(posedge clk_i);
      #1;
      chk("lat_s2_valid", rsp_valid_o, 1);
      chk("lat_s2_hit", rsp_hit_o, 1);
      chk("lat_s2_idx", rsp_idx_o, 0);
      lookup(64'h7820_0000);
      drain();
      chk("miss_err_valid", err_valid_o, 1);
      chk("miss_err_addr", err_addr_o, 64'h7820_0000);
      chk("miss_err_cnt", err_cnt_o, 1);

      // overlapping regions
      region(2, 64'h5000_0000, 64'h80_0000);
      region(5, 64'h5040_0000, 64'h100_0000);
      lookup(64'h5050_0000);
      @(posedge clk_i);
      #1;
      chk("ovl_hit", rsp_hit_o, 1);
      chk("ovl_idx", rsp_idx_o, 2);
      chk("ovl_multi", rsp_multi_o, 1);
      drain();
      chk("ovl_err_cnt", err_cnt_o, 1);

      // backpressure: two accepted, then ready drops
      rsp_ready_i = 1'b0;
      lookup(64'h7800_0100);
      lookup(64'h0000_1000);
      req_valid_i = 1'b1;
      req_addr_i  = 64'h5000_0000;
      repeat (3) begin
         @(negedge clk_i);
         chk("bp_req_ready", req_ready_o, 0);
         @(posedge clk_i);
         #1;
      end
      rsp_ready_i = 1'b1;
      lookup(64'h5000_0000);
      lookup(64'h5100_0000);
      drain();
      chk("bp_queue_empty", q.size(), 0);

      // config request while two lookups are in flight
      region(1, 64'h6000_0000, 64'h1000);
      rsp_ready_i = 1'b0;
      lookup(64'h6000_0010);
      lookup(64'h6000_0020);
      cfg_valid_i = 1'b1;
      cfg_idx_i   = 3'd1;
      cfg_field_i = 2'd2;
      cfg_wdata_i = '0;
      @(negedge clk_i);
      chk("cfgw_req_ready", req_ready_o, 0);
      chk("cfgw_cfg_ready", cfg_ready_o, 0);
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!cfg_ready_o && n < 50);
      chk("cfgw_drained", q.size(), 0);
      chk("cfgw_ready_seen", cfg_ready_o, 1);
      @(posedge clk_i);
      #1;
      cfg_valid_i = 1'b0;
      lookup(64'h6000_0010);
      @(posedge clk_i);
      #1;
      chk("cfgw_r1_miss", rsp_hit_o, 0);
      drain();

      // wrap to top of address space, reserved field, zero size
      region(7, 64'hFFFF_FFFF_FFFF_F000, 64'h2000);
      lookup(64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk_i);
      #1;
      chk("wrap_hit", rsp_hit_o, 1);
      chk("wrap_idx", rsp_idx_o, 7);
      drain();
      cfg_write(7, 3, 64'h0);
      lookup(64'hFFFF_FFFF_FFFF_F000);
      @(posedge clk_i);
      #1;
      chk("rsvd_hit", rsp_hit_o, 1);
      chk("rsvd_idx", rsp_idx_o, 7);
      lookup(64'h0);
      region(3, 64'h9000_0000, 64'h0);
      lookup(64'h9000_0000);
      @(posedge clk_i);
      #1;
      chk("size0_hit", rsp_hit_o, 0);
      drain();

      // saturation and clear-with-miss
      for (int i = 0; i < 300; i++) begin
         lookup(64'h1000 + 64'(i));
      end
      drain();
      chk("sat_err_cnt", err_cnt_o, 255);
      chk("sat_err_addr", err_addr_o, 64'h7820_0000);
      lookup(64'h2222_0000);
      @(posedge clk_i);
      #1;
      err_clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      err_clear_i = 1'b0;
      chk("clr_err_valid", err_valid_o, 1);
      chk("clr_err_addr", err_addr_o, 64'h2222_0000);
      chk("clr_err_cnt", err_cnt_o, 1);

      // reset in the middle of traffic
      rsp_ready_i = 1'b0;
      lookup(64'h7800_0000);
      lookup(64'h7800_0004);
      #2;
      rst_i = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_err_cnt", err_cnt_o, 0);
      reset_model();
      @(posedge clk_i);
      #1;
      rst_i       = 1'b0;
      rsp_ready_i = 1'b1;
      lookup(64'h7800_0000);
      @(posedge clk_i);
      #1;
      chk("post_rst_miss", rsp_hit_o, 0);
      drain();
      chk("post_rst_err_cnt", err_cnt_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
